vx_mem_port_arbiter: RTL and testbench
======================================

Name: vx_mem_port_arbiter

Overview:
- Shares the single Vortex memory port (mem_req_*/mem_rsp_*) between NUM_REQS upstream requesters, e.g. cluster memory slices and the DCR-load/DMA engine.
- Arbitrates requests round-robin through a one-entry registered output stage.
- Extends each request tag with the requester index and demultiplexes responses back by that index.
- Limits in-flight reads so a slow memory pipeline cannot overflow downstream tag tracking.

Parameters:
- NUM_REQS, 4, number of requesters (≥2, power of two).
- ADDR_WIDTH, 26, memory line address width.
- DATA_WIDTH, 512, memory line data width.
- TAG_IN_WIDTH, 8, per-requester tag width.
- MAX_OUTSTANDING, 16, maximum reads in flight (≥1).
- Derived: SEL_W = log2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_req_valid  in  NUM_REQS  per-requester request valid
- in_req_rw  in  NUM_REQS  1=write, 0=read
- in_req_byteen  in  NUM_REQS*DATA_WIDTH/8  byte enables
- in_req_addr  in  NUM_REQS*ADDR_WIDTH  line addresses
- in_req_data  in  NUM_REQS*DATA_WIDTH  write data
- in_req_tag  in  NUM_REQS*TAG_IN_WIDTH  requester tags
- in_req_ready  out  NUM_REQS  per-requester accept
- in_rsp_valid  out  NUM_REQS  response valid, one-hot
- in_rsp_data  out  DATA_WIDTH  response data, shared
- in_rsp_tag  out  TAG_IN_WIDTH  original tag, shared
- in_rsp_ready  in  NUM_REQS  per-requester response ready
- mem_req_valid/rw/byteen/addr/data  out  1/1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  memory request
- mem_req_tag  out  TAG_OUT_WIDTH  {requester index, original tag}, index in MSBs
- mem_req_ready  in  1  memory accept
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_WIDTH  response data
- mem_rsp_tag  in  TAG_OUT_WIDTH  response tag
- mem_rsp_ready  out  1  response accept
- perf_reads, perf_writes, perf_stalls  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset: mem_req_valid=0, output stage payload=0, RR pointer=0, outstanding count=0, perf counters=0. All in_req_ready=0 while reset is high.
- Eligibility:
  - Requester i is eligible when in_req_valid[i] is high and (in_req_rw[i] or count<MAX_OUTSTANDING).
  - Blocked reads do not stall eligible writes from other requesters.
- Grant: round-robin among eligible requesters, starting at the pointer. Exactly one grant per cycle.
- Stage free: stage_free = ~mem_req_valid | mem_req_ready.
- Ready: in_req_ready[i] = grant[i] & stage_free. A requester's ready must never depend on another requester's valid beyond the arbitration itself.
- Acceptance (cycle N): the granted request is loaded into the output stage. mem_req_valid=1 from cycle N+1, giving 1 cycle of latency.
  - Payload is held stable while mem_req_valid & ~mem_req_ready.
  - Back-to-back requests sustain 1 per cycle when mem_req_ready=1.
- Pointer update: on acceptance, pointer becomes winner+1 modulo NUM_REQS. Otherwise the pointer is unchanged.
- Outstanding count:
  - +1 on read acceptance; −1 on mem_rsp handshake; unchanged when both occur in the same cycle.
  - Saturates at 0: a response after a reset mid-operation must not underflow. Such a response is still forwarded.
  - Writes produce no response and are never counted.
- Response path (combinational):
  - idx = mem_rsp_tag MSBs.
  - in_rsp_valid[idx] = mem_rsp_valid; all other in_rsp_valid bits are 0.
  - in_rsp_tag = mem_rsp_tag LSBs; in_rsp_data = mem_rsp_data.
  - mem_rsp_ready = in_rsp_ready[idx].
- Reset mid-operation: the output stage is dropped (mem_req_valid=0 next cycle) and the count is cleared.

Optional Feature:
- Macro: VX_MEM_ARB_PERF_EN.
- Defined:
  - perf_reads increments per accepted read.
  - perf_writes increments per accepted write.
  - perf_stalls increments each cycle where any in_req_valid is high and no request is accepted.
  - All three wrap at 2^32.
- Undefined: all perf outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package VX_gpu_pkg: MEM_ARB_SEL_W function/constant and a mem_req_t struct (rw, byteen, addr, data, tag) used for the output stage.
- Sub-module vx_rr_arbiter:
  - Parameter NUM_REQS.
  - Inputs requests, advance, clk, reset.
  - Outputs one-hot grant and grant index.
  - Owns the RR pointer.

Test Plan:
- All 4 requesters issue 1 read each in the same cycle, mem_req_ready=1 → mem_req_tag MSBs 0,1,2,3 on consecutive cycles starting N+1; in_req_ready pulses one-hot per cycle.
- Requester 2 issues a write (addr 0x40, byteen all-ones) while mem_req_ready=0 for 5 cycles → mem_req_* stable for 5 cycles; count stays 0; no response expected.
- MAX_OUTSTANDING=16: 16 reads are accepted with no responses, then a 17th read plus a write from requester 3 → read blocked, write accepted; one response returned → read accepted the next cycle.
- mem_rsp_tag={2'd1, 8'hA5} with in_rsp_ready[1]=0 → in_rsp_valid=4'b0010, mem_rsp_ready=0; raise in_rsp_ready[1] → handshake completes, count decrements by 1.
- Read acceptance and response in the same cycle with count=5 → count remains 5.
- Reset asserted with mem_req_valid=1 and count=3 → mem_req_valid=0 and count=0 next cycle; a late response forwards with count held at 0. Perf counters all 0 when the macro is undefined.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared memory-arbiter types: requester-index width helper and the registered request stage layout.
// The stage struct is sized by the package widths; override the arbiter parameters together with these.
package VX_gpu_pkg;

  localparam int MEM_NUM_REQS     = 4;
  localparam int MEM_ADDR_WIDTH   = 26;
  localparam int MEM_DATA_WIDTH   = 512;
  localparam int MEM_TAG_IN_WIDTH = 8;

  function automatic int MEM_ARB_SEL_W(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  localparam int MEM_TAG_OUT_WIDTH = MEM_TAG_IN_WIDTH + MEM_ARB_SEL_W(MEM_NUM_REQS);

  typedef struct packed {
    logic                          rw;
    logic [MEM_DATA_WIDTH/8-1:0]   byteen;
    logic [MEM_ADDR_WIDTH-1:0]     addr;
    logic [MEM_DATA_WIDTH-1:0]     data;
    logic [MEM_TAG_OUT_WIDTH-1:0]  tag;
  } mem_req_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer; pointer moves past
// the winner only when the grant is consumed (advance).
module vx_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int SEL_W   = MEM_ARB_SEL_W(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;

  // NUM_REQS is a power of two, so pointer + offset wraps naturally
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQS; off++) begin
      idx = ptr + SEL_W'(off);
      if (!found && requests[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_mem_port_arbiter.sv
// Shares one memory port among NUM_REQS requesters via round-robin into a one-entry output stage,
// with tag extension, response demux and a cap on reads in flight. Perf counters under VX_MEM_ARB_PERF_EN.
module vx_mem_port_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS        = MEM_NUM_REQS,
  parameter int ADDR_WIDTH      = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = MEM_DATA_WIDTH,
  parameter int TAG_IN_WIDTH    = MEM_TAG_IN_WIDTH,
  parameter int MAX_OUTSTANDING = 16,
  localparam int SEL_W          = MEM_ARB_SEL_W(NUM_REQS),
  localparam int TAG_OUT_WIDTH  = TAG_IN_WIDTH + SEL_W
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [NUM_REQS-1:0]              in_req_valid,
  input  logic [NUM_REQS-1:0]              in_req_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0]              in_req_ready,

  output logic [NUM_REQS-1:0]              in_rsp_valid,
  output logic [DATA_WIDTH-1:0]            in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag,
  input  logic [NUM_REQS-1:0]              in_rsp_ready,

  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,

  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,

  output logic [31:0]                      perf_reads,
  output logic [31:0]                      perf_writes,
  output logic [31:0]                      perf_stalls
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]    out_cnt;
  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                stage_free;
  logic                accept;
  logic                rd_accept;
  logic                rsp_fire;
  logic [SEL_W-1:0]    rsp_idx;
  mem_req_t            stage;
  mem_req_t            stage_nxt;

  // A write never waits on the read cap, so blocked reads cannot starve writes
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = in_req_valid[i] & (in_req_rw[i] | (out_cnt < CNT_W'(MAX_OUTSTANDING)));
    end
  end

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) rr_arb (
    .clk       (clk),
    .reset     (reset),
    .requests  (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign stage_free   = ~mem_req_valid | mem_req_ready;
  assign in_req_ready = grant & {NUM_REQS{stage_free & ~reset}};
  assign accept       = |in_req_ready;
  assign rd_accept    = accept & ~in_req_rw[grant_idx];

  always_comb begin
    stage_nxt        = '0;
    stage_nxt.rw     = in_req_rw[grant_idx];
    stage_nxt.byteen = in_req_byteen[grant_idx*(DATA_WIDTH/8) +: DATA_WIDTH/8];
    stage_nxt.addr   = in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    stage_nxt.data   = in_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    stage_nxt.tag    = {grant_idx, in_req_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      stage         <= '0;
    end else if (stage_free) begin
      mem_req_valid <= accept;
      if (accept) begin
        stage <= stage_nxt;
      end
    end
  end

  assign mem_req_rw     = stage.rw;
  assign mem_req_byteen = stage.byteen;
  assign mem_req_addr   = stage.addr;
  assign mem_req_data   = stage.data;
  assign mem_req_tag    = stage.tag;

  assign rsp_idx       = mem_rsp_tag[TAG_OUT_WIDTH-1 -: SEL_W];
  assign in_rsp_valid  = mem_rsp_valid ? (NUM_REQS'(1) << rsp_idx) : '0;
  assign in_rsp_tag    = mem_rsp_tag[TAG_IN_WIDTH-1:0];
  assign in_rsp_data   = mem_rsp_data;
  assign mem_rsp_ready = in_rsp_ready[rsp_idx];
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

  // Responses that outlive a reset are forwarded but must not drive the count below zero
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= '0;
    end else if (rd_accept & ~rsp_fire) begin
      out_cnt <= out_cnt + 1'b1;
    end else if (~rd_accept & rsp_fire & (out_cnt != '0)) begin
      out_cnt <= out_cnt - 1'b1;
    end
  end

`ifdef VX_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_accept) perf_reads <= perf_reads + 32'd1;
      if (accept & ~rd_accept) perf_writes <= perf_writes + 32'd1;
      if ((|in_req_valid) & ~accept) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  assign perf_reads  = '0;
  assign perf_writes = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_mem_port_arbiter.sv
// Directed bench for vx_mem_port_arbiter: expected memory requests go into a queue that a
// negedge monitor drains on each mem_req handshake; response path and read cap checked inline.
module tb_vx_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int OW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*DW/8-1:0] in_req_byteen;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [DW-1:0]   in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;
  logic            mem_req_valid, mem_req_rw, mem_req_ready;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [OW-1:0]   mem_req_tag;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_data;
  logic [OW-1:0]   mem_rsp_tag;
  logic [31:0]     perf_reads, perf_writes, perf_stalls;

  vx_mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [25:0] addr;
    logic [9:0]  tag;
    logic [31:0] be;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [25:0] a, input logic [9:0] t,
                      input logic [31:0] be, input logic [31:0] d);
    exp_t e;
    e.rw = rw; e.addr = a; e.tag = t; e.be = be; e.d = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: one expected entry consumed per memory-side handshake
  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_req", {1'b1, mem_req_tag}, '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mem_req", {mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen[31:0], mem_req_data[31:0]},
            {e.rw, e.addr, e.tag, e.be, e.d});
      end
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [25:0] a, input logic [7:0] t,
                         input logic [31:0] be, input logic [31:0] d);
    in_req_valid[i] = 1'b1;
    in_req_rw[i]    = rw;
    in_req_addr[i*AW +: AW] = a;
    in_req_tag[i*TW +: TW]  = t;
    in_req_byteen[i*64 +: 64] = {2{be}};
    in_req_data[i*DW +: DW]   = {16{d}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    reset = 1'b1;
    in_req_valid = '0; mem_rsp_valid = 1'b0; in_rsp_ready = '1; mem_req_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_req_valid = '1; in_req_rw = '0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = '1; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", 128'(in_req_ready), 128'd0);
    chk("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_payload", {mem_req_addr, mem_req_tag, mem_req_data[31:0]}, 128'd0);
    chk("rst_count", 128'(dut.out_cnt), 128'd0);
    chk("rst_perf", {perf_reads, perf_writes, perf_stalls}, 128'd0);
    do_reset();

    // 1) four simultaneous reads drain 0,1,2,3 with one-hot ready pulses
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 26'h1000 + 26'(i), 8'h10 + 8'(i), 32'hF0F0_0000 + i, 32'hA000_0000 + i);
    for (int i = 0; i < N; i++) push(1'b0, 26'h1000 + 26'(i), {2'(i), 8'h10 + 8'(i)}, 32'hF0F0_0000 + i, 32'hA000_0000 + i);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("rr_ready", 128'(in_req_ready), 128'(4'b0001 << k));
      tick();
      in_req_valid[k] = 1'b0;
    end
    tick(); tick();
    chk("rr_count", 128'(dut.out_cnt), 128'd4);
    do_reset();

    // 2) write from requester 2 held under backpressure for 5 cycles
    mem_req_ready = 1'b0;
    set_req(2, 1'b1, 26'h40, 8'h33, 32'hFFFF_FFFF, 32'h1234_5678);
    push(1'b1, 26'h40, 10'h233, 32'hFFFF_FFFF, 32'h1234_5678);
    @(negedge clk);
    chk("wr_ready", 128'(in_req_ready), 128'b0100);
    tick();
    in_req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wr_hold", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen[63:32]},
          {1'b1, 1'b1, 26'h40, 10'h233, 32'hFFFF_FFFF});
      chk("wr_count", 128'(dut.out_cnt), 128'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    do_reset();

    // 3) read cap: 16 reads in flight, 17th blocked while a write passes
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b0, 26'(k), 8'(k), 32'h0, 32'hB000_0000 + k);
      push(1'b0, 26'(k), 10'(k), 32'h0, 32'hB000_0000 + k);
      @(negedge clk);
      chk("cap_fill_ready", 128'(in_req_ready), 128'b0001);
      tick();
    end
    set_req(0, 1'b0, 26'h100, 8'h10, 32'h0, 32'hC0DE_0017);
    set_req(3, 1'b1, 26'h200, 8'h77, 32'h5555_AAAA, 32'hC0DE_0003);
    push(1'b1, 26'h200, 10'h377, 32'h5555_AAAA, 32'hC0DE_0003);
    @(negedge clk);
    chk("cap_write_passes", 128'(in_req_ready), 128'b1000);
    chk("cap_count16", 128'(dut.out_cnt), 128'd16);
    tick();
    in_req_valid[3] = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd0, 8'h00}; mem_rsp_data = '0;
    @(negedge clk);
    chk("cap_read_blocked", 128'(in_req_ready), 128'b0000);
    chk("cap_rsp_valid", 128'(in_rsp_valid), 128'b0001);
    push(1'b0, 26'h100, 10'h010, 32'h0, 32'hC0DE_0017);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("cap_read_after_rsp", 128'(in_req_ready), 128'b0001);
    tick();
    in_req_valid = '0;
    tick(); tick();
    chk("cap_count_end", 128'(dut.out_cnt), 128'd16);
    do_reset();

    // 4) response routing with requester backpressure
    set_req(1, 1'b0, 26'h11, 8'h21, 32'h0, 32'h0000_0011);
    push(1'b0, 26'h11, 10'h121, 32'h0, 32'h0000_0011);
    @(negedge clk);
    chk("rsp_req_ready", 128'(in_req_ready), 128'b0010);
    tick();
    in_req_valid = '0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd1, 8'hA5}; mem_rsp_data = {16{32'hDEAD_BEEF}};
    in_rsp_ready = 4'b1101;
    @(negedge clk);
    chk("rsp_valid_onehot", 128'(in_rsp_valid), 128'b0010);
    chk("rsp_ready_blocked", 128'(mem_rsp_ready), 128'd0);
    chk("rsp_tag_data", {in_rsp_tag, in_rsp_data[63:0]}, {8'hA5, 64'hDEAD_BEEF_DEAD_BEEF});
    tick();
    chk("rsp_count_held", 128'(dut.out_cnt), 128'd1);
    in_rsp_ready = 4'b1111;
    @(negedge clk);
    chk("rsp_ready_open", 128'(mem_rsp_ready), 128'd1);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rsp_count_dec", 128'(dut.out_cnt), 128'd0);
    do_reset();

    // 5) simultaneous read accept and response at count 5
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b0, 26'h300 + 26'(k), 8'h40 + 8'(k), 32'h0, 32'hE000_0000 + k);
      push(1'b0, 26'h300 + 26'(k), 10'h040 + 10'(k), 32'h0, 32'hE000_0000 + k);
      if (k == 5) begin
        mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd0, 8'h40};
        @(negedge clk);
        chk("both_count_before", 128'(dut.out_cnt), 128'd5);
      end
      tick();
    end
    in_req_valid = '0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("both_count_after", 128'(dut.out_cnt), 128'd5);
    tick();
    do_reset();

    // 6) reset with a held request and 3 reads in flight, then a late response
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b0, 26'h500 + 26'(k), 8'(k), 32'h0, 32'h7000_0000 + k);
      if (k < 2) push(1'b0, 26'h500 + 26'(k), 10'(k), 32'h0, 32'h7000_0000 + k);
      tick();
    end
    in_req_valid = '0; mem_req_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_state", {mem_req_valid, mem_req_tag, 5'(dut.out_cnt)}, {1'b1, 10'h002, 5'd3});
    tick();
    reset = 1'b1;
    set_req(1, 1'b0, 26'h1, 8'h1, 32'h0, 32'h1);
    @(negedge clk);
    chk("rst_mid_ready", 128'(in_req_ready), 128'd0);
    tick();
    reset = 1'b0;
    in_req_valid = '0; mem_req_ready = 1'b1;
    chk("rst_mid_state", {mem_req_valid, 5'(dut.out_cnt)}, {1'b0, 5'd0});
    mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd3, 8'h5C}; in_rsp_ready = 4'b1000;
    @(negedge clk);
    chk("late_rsp_fwd", {in_rsp_valid, mem_rsp_ready, in_rsp_tag}, {4'b1000, 1'b1, 8'h5C});
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_count", 128'(dut.out_cnt), 128'd0);
    chk("perf_after_rst", {perf_reads, perf_writes, perf_stalls}, 128'd0);
    chk("final_queue", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
